wb_seq_master: RTL

Wishbone initiator used to drive the synth register block, e.g. from a sequencer or test controller instead of the management core. It accepts single-word commands on a valid/ready request port and runs exactly one classic Wishbone single read or write per command. It returns read data or a timeout error on a valid/ready response port, with one transaction outstanding at a time.

---
 rtl/wb_seq_master_if.sv | 45 ++++
 rtl/wb_seq_master.sv | 129 ++++++++++++
 2 files changed

// File: rtl/wb_seq_master_if.sv
// Bus bundle for wb_seq_master: command port, response port and the
// Wishbone initiator signals. The master modport is the sequencer side; the
// slave modport is the view seen by whatever drives commands and acks.
interface wb_seq_master_if #(
  parameter int AW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [31:0]   cmd_dat;
  logic [3:0]    cmd_sel;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;

  logic          wbs_cyc_o;
  logic          wbs_stb_o;
  logic          wbs_we_o;
  logic [3:0]    wbs_sel_o;
  logic [AW-1:0] wbs_adr_o;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_i;
  logic [31:0]   wbs_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_ack_i, wbs_dat_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    output wbs_ack_i, wbs_dat_i
  );
endinterface

// File: rtl/wb_seq_master.sv
// Single-outstanding Wishbone initiator: one classic single read or write per
// accepted command, with read data or a timeout error returned on a
// valid/ready response port. All outputs are registered.
module wb_seq_master #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  wb_seq_master_if.master bus
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit            TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state_reg,     state_next;
  logic [CW-1:0] cnt_reg,       cnt_next;
  logic          cmd_ready_reg, cmd_ready_next;
  logic          cyc_reg,       cyc_next;
  logic          we_reg,        we_next;
  logic [3:0]    sel_reg,       sel_next;
  logic [AW-1:0] adr_reg,       adr_next;
  logic [31:0]   dat_reg,       dat_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [31:0]   rsp_dat_reg,   rsp_dat_next;
  logic          rsp_err_reg,   rsp_err_next;

  // State and every output register; reset clears the lot asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= '0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cmd_ready_reg <= cmd_ready_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_dat_reg   <= rsp_dat_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // Next-state and next-output decode; everything holds unless a case moves it.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cmd_ready_next = 1'b0;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    adr_next       = adr_reg;
    dat_next       = dat_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_dat_next   = rsp_dat_reg;
    rsp_err_next   = rsp_err_reg;
    case (state_reg)
      IDLE: begin
        // cmd_ready is only ever high in IDLE, so it gates the accept.
        cmd_ready_next = 1'b1;
        if (bus.cmd_valid && cmd_ready_reg) begin
          cmd_ready_next = 1'b0;
          we_next        = bus.cmd_we;
          adr_next       = bus.cmd_adr;
          dat_next       = bus.cmd_dat;
          sel_next       = bus.cmd_sel;
          cyc_next       = 1'b1;
          cnt_next       = '0;
          state_next     = BUS;
        end
      end
      BUS: begin
        if (bus.wbs_ack_i) begin
          // Ack beats a simultaneous timeout expiry.
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = we_reg ? 32'h0 : bus.wbs_dat_i;
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = 32'h0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end else if (cnt_reg != {CW{1'b1}}) begin
          // Saturate rather than wrap when the timeout is disabled.
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_dat   = rsp_dat_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.wbs_cyc_o = cyc_reg;
  assign bus.wbs_stb_o = cyc_reg;
  assign bus.wbs_we_o  = we_reg;
  assign bus.wbs_sel_o = sel_reg;
  assign bus.wbs_adr_o = adr_reg;
  assign bus.wbs_dat_o = dat_reg;

endmodule
